// File: rtl/event_blinker.sv
// Stretches single-cycle event strobes into fixed-length blinks separated by a
// fixed dark gap; events arriving mid-blink are queued in a saturating counter.
module event_blinker #(
   parameter logic        OUTPUT_WHEN_IDLE = 1'b0,
   parameter int unsigned ON_CYCLES        = 1000,
   parameter int unsigned OFF_CYCLES       = 1000,
   parameter int unsigned MAX_PENDING      = 15
) (
   input  logic                               clk,
   input  logic                               rst_n,
   // `event` is a reserved word in SystemVerilog, so the strobe is named evt
   input  logic                               evt,
   output logic                               out,
   output logic                               busy,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               overflow
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);
   localparam int unsigned PW      = $clog2(MAX_PENDING + 1);

   // Timer is loaded with N-1 and the phase ends on the edge that sees zero,
   // so each phase spans exactly N clock edges.
   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      GAP
   } state_t;

   state_t        state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic [PW-1:0] pending_nx;
   logic          drop;

   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      pending_nx = pending;
      drop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (evt) begin
               state_nx = ON;
               timer_nx = ON_LOAD;
            end
         end
         ON: begin
            if (timer == '0) begin
               state_nx = GAP;
               timer_nx = OFF_LOAD;
            end else begin
               timer_nx = timer - 1'b1;
            end
            if (evt) begin
               if (pending == PEND_MAX) drop = 1'b1;
               else                     pending_nx = pending + 1'b1;
            end
         end
         GAP: begin
            if (timer == '0) begin
               // A coincident event replaces the dequeued one (or starts the
               // next blink directly when nothing is queued).
               if (pending != '0) begin
                  state_nx = ON;
                  timer_nx = ON_LOAD;
                  if (!evt) pending_nx = pending - 1'b1;
               end else if (evt) begin
                  state_nx = ON;
                  timer_nx = ON_LOAD;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               timer_nx = timer - 1'b1;
               if (evt) begin
                  if (pending == PEND_MAX) drop = 1'b1;
                  else                     pending_nx = pending + 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         out      <= OUTPUT_WHEN_IDLE;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         timer    <= timer_nx;
         pending  <= pending_nx;
         overflow <= drop;
         out      <= (state_nx == ON) ? ~OUTPUT_WHEN_IDLE : OUTPUT_WHEN_IDLE;
         busy     <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker: vector table, hand-built reset sequences and random
// events checked against a blink-schedule reference model.
module tb_event_blinker;

   localparam int unsigned ON   = 3;
   localparam int unsigned OFF  = 2;
   localparam int unsigned MAXP = 2;

   logic       clk = 1'b0;
   logic       rst_n, evt, out, busy, overflow;
   logic [1:0] pending;
   logic       rst1_n, evt1, out1, busy1, overflow1;
   logic [1:0] pending1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   event_blinker #(
      .OUTPUT_WHEN_IDLE(1'b0), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .evt(evt), .out(out), .busy(busy),
      .pending(pending), .overflow(overflow)
   );

   event_blinker #(
      .OUTPUT_WHEN_IDLE(1'b1), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP)
   ) dut1 (
      .clk(clk), .rst_n(rst1_n), .evt(evt1), .out(out1), .busy(busy1),
      .pending(pending1), .overflow(overflow1)
   );

   // Reference: a blink is "active" for ON+OFF edges from its start edge m_s.
   bit m_active;
   int m_s, m_n, m_q;
   bit m_ovf;

   task automatic model_reset();
      m_active = 1'b0;
      m_q      = 0;
      m_ovf    = 1'b0;
   endtask

   task automatic model_step(input bit e);
      m_n++;
      m_ovf = 1'b0;
      if (m_active && (m_n - m_s) >= int'(ON + OFF)) m_active = 1'b0;
      if (!m_active) begin
         if (e) begin
            m_active = 1'b1;
            m_s      = m_n;
         end else if (m_q > 0) begin
            m_active = 1'b1;
            m_s      = m_n;
            m_q--;
         end
      end else if (e) begin
         if (m_q < int'(MAXP)) m_q++;
         else                  m_ovf = 1'b1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cycle(input bit e);
      bit mo, mb;
      evt = e;
      @(posedge clk);
      model_step(e);
      #1;
      mo = m_active && (m_n - m_s) < int'(ON);
      mb = m_active;
      chk("out", int'(out), int'(mo));
      chk("busy", int'(busy), int'(mb));
      chk("pending", int'(pending), m_q);
      chk("overflow", int'(overflow), int'(m_ovf));
   endtask

   typedef struct {
      bit e;
      bit o;
      bit b;
      int p;
      bit ov;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit e, input bit o, input bit b, input int p, input bit ov);
      vec_t v;
      v.e = e; v.o = o; v.b = b; v.p = p; v.ov = ov;
      tbl.push_back(v);
   endtask

   initial begin
      // overflow: events on four consecutive edges, fourth is dropped
      add(1,1,1,0,0); add(1,1,1,1,0); add(1,1,1,2,0); add(1,0,1,2,1);
      add(0,0,1,2,0); add(0,1,1,1,0); add(0,1,1,1,0); add(0,1,1,1,0);
      add(0,0,1,1,0); add(0,0,1,1,0); add(0,1,1,0,0); add(0,1,1,0,0);
      add(0,1,1,0,0); add(0,0,1,0,0); add(0,0,1,0,0); add(0,0,0,0,0);
      add(0,0,0,0,0);
      // coincident event and dequeue at relative edge 5
      add(1,1,1,0,0); add(1,1,1,1,0); add(0,1,1,1,0); add(0,0,1,1,0);
      add(0,0,1,1,0); add(1,1,1,1,0); add(0,1,1,1,0); add(0,1,1,1,0);
      add(0,0,1,1,0); add(0,0,1,1,0); add(0,1,1,0,0); add(0,1,1,0,0);
      add(0,1,1,0,0); add(0,0,1,0,0); add(0,0,1,0,0); add(0,0,0,0,0);
      add(0,0,0,0,0);

      rst_n = 1'b0; rst1_n = 1'b0; evt = 1'b0; evt1 = 1'b0;
      m_n = 0; m_s = 0;
      model_reset();

      // held in reset with event toggling
      for (int i = 0; i < 6; i++) begin
         evt  = ~evt;
         evt1 = ~evt1;
         @(posedge clk);
         #1;
         chk("rst_out", int'(out), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_pending", int'(pending), 0);
         chk("rst_overflow", int'(overflow), 0);
      end
      chk("rst_out1", int'(out1), 1);
      chk("rst_busy1", int'(busy1), 0);
      rst_n = 1'b1; rst1_n = 1'b1; evt = 1'b0; evt1 = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0);
      cycle(1'b1);
      chk("rel_out", int'(out), 1);
      for (int i = 0; i < 8; i++) cycle(1'b0);

      // single event
      cycle(1'b1);
      chk("single_out_k", int'(out), 1);
      cycle(1'b0); cycle(1'b0);
      chk("single_out_k2", int'(out), 1);
      cycle(1'b0);
      chk("single_out_k3", int'(out), 0);
      chk("single_busy_k3", int'(busy), 1);
      cycle(1'b0);
      cycle(1'b0);
      chk("single_busy_k5", int'(busy), 0);
      for (int i = 0; i < 3; i++) cycle(1'b0);

      foreach (tbl[i]) begin
         cycle(tbl[i].e);
         chk("tbl_out", int'(out), int'(tbl[i].o));
         chk("tbl_busy", int'(busy), int'(tbl[i].b));
         chk("tbl_pending", int'(pending), tbl[i].p);
         chk("tbl_overflow", int'(overflow), int'(tbl[i].ov));
      end

      // inverted polarity, reset mid-blink with one event queued
      evt1 = 1'b1;
      @(posedge clk); #1;
      chk("pol_out_on", int'(out1), 0);
      chk("pol_busy", int'(busy1), 1);
      @(posedge clk); #1;
      evt1 = 1'b0;
      chk("pol_pending", int'(pending1), 1);
      #4;
      rst1_n = 1'b0;
      #1;
      chk("pol_rst_out", int'(out1), 1);
      chk("pol_rst_busy", int'(busy1), 0);
      chk("pol_rst_pending", int'(pending1), 0);
      chk("pol_rst_overflow", int'(overflow1), 0);
      @(posedge clk); #1;
      rst1_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("pol_after_out", int'(out1), 1);
         chk("pol_after_busy", int'(busy1), 0);
      end

      // random event density, segment by segment
      for (int seg = 0; seg < 16; seg++) begin
         int dens;
         dens = int'($urandom_range(2, 90));
         for (int i = 0; i < 150; i++) cycle($urandom_range(0, 99) < dens);
      end
      for (int i = 0; i < 20; i++) cycle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
